// File: rtl/resp_arb_pkg.sv
// Shared types and helpers for the response arbiter.
// Holds the FSM state encoding and the index/pointer width calculation.
package resp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Width of a source index; a single source still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational request picker.
// Selects by round-robin from ptr (rr_mode=1) or by lowest index (rr_mode=0).
module rr_pick
  import resp_arb_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int IW      = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               rr_mode,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IW-1:0]      idx
);

  logic found;
  int   j;

  // Walk the sources in search order; only real indices are ever visited.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = rr_mode ? ((int'(ptr) + k) % NUM_SRC) : k;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/resp_arb.sv
// Response arbiter: serialises bytes from NUM_SRC producers onto the UART handshake
// with fixed-priority or round-robin arbitration, burst lock and a resp_sent watchdog.
module resp_arb
  import resp_arb_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 8,
  parameter int RR_MODE = 1,
  parameter int TO_CYC  = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_req,
  input  logic [NUM_SRC*DATA_W-1:0]     src_data,
  input  logic [NUM_SRC-1:0]            src_lock,
  output logic [NUM_SRC-1:0]            src_ack,
  output logic [NUM_SRC-1:0]            src_done,
  output logic [DATA_W-1:0]             resp_data,
  output logic                          send_resp,
  input  logic                          resp_sent,
  output logic                          busy,
  output logic [idx_width(NUM_SRC)-1:0] grant_id,
  output logic                          timeout_err,
  input  logic                          clr_err
);

  localparam int IW = idx_width(NUM_SRC);
  localparam int WW = $clog2(TO_CYC);

  state_t               state, state_nxt;
  logic [IW-1:0]        ptr;
  logic [WW-1:0]        wd;
  logic                 locked_grant;
  logic                 lock_hit;
  logic                 wd_exp;
  logic                 set_err;
  logic [NUM_SRC-1:0]   grant_oh;
  logic [NUM_SRC-1:0]   elig;
  logic [NUM_SRC-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;

  // A held lock restricts eligibility to the last owner, even while its req is low.
  assign grant_oh = NUM_SRC'(1) << grant_id;
  assign lock_hit = src_lock[grant_id];
  assign elig     = lock_hit ? (src_req & grant_oh) : src_req;
  assign wd_exp   = (wd == WW'(TO_CYC - 1));
  assign set_err  = (state == WAIT) && !resp_sent && wd_exp;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IW      (IW)
  ) u_pick (
    .req     (elig),
    .ptr     (ptr),
    .rr_mode (RR_MODE[0]),
    .gnt     (pick_gnt),
    .idx     (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    send_resp = 1'b0;
    src_ack   = '0;
    busy      = 1'b0;
    case (state)
      IDLE: if (|pick_gnt) state_nxt = SEND;
      SEND: begin
        send_resp = 1'b1;
        src_ack   = grant_oh;
        busy      = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (resp_sent || wd_exp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture, pointer, watchdog and done pulse; locked re-grants leave the pointer alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data    <= '0;
      grant_id     <= '0;
      locked_grant <= 1'b0;
      ptr          <= '0;
      wd           <= '0;
      src_done     <= '0;
    end else begin
      src_done <= '0;
      case (state)
        IDLE: begin
          if (|pick_gnt) begin
            resp_data    <= src_data[pick_idx*DATA_W +: DATA_W];
            grant_id     <= pick_idx;
            locked_grant <= lock_hit;
          end
        end
        SEND: wd <= '0;
        WAIT: begin
          if (resp_sent) begin
            src_done <= grant_oh;
            if (!locked_grant)
              ptr <= (grant_id == IW'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
          end else if (wd_exp) begin
            src_done <= grant_oh;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A new expiry outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       timeout_err <= 1'b0;
    else if (set_err) timeout_err <= 1'b1;
    else if (clr_err) timeout_err <= 1'b0;
  end

endmodule

// File: tb/tb_resp_arb.sv
// Directed bench for resp_arb: dut_a is round-robin, dut_b is fixed priority,
// both with a 10-cycle watchdog.
module tb_resp_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  src_req_a, src_req_b, src_lock_a;
  logic [23:0] src_data;
  logic        resp_sent_a, resp_sent_b, clr_err;
  logic [2:0]  src_ack_a, src_done_a, src_ack_b, src_done_b;
  logic [7:0]  resp_data_a, resp_data_b;
  logic        send_resp_a, send_resp_b, busy_a, busy_b, timeout_err_a, timeout_err_b;
  logic [1:0]  grant_id_a, grant_id_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  resp_arb #(.NUM_SRC(3), .DATA_W(8), .RR_MODE(1), .TO_CYC(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .src_req(src_req_a), .src_data(src_data),
    .src_lock(src_lock_a), .src_ack(src_ack_a), .src_done(src_done_a),
    .resp_data(resp_data_a), .send_resp(send_resp_a), .resp_sent(resp_sent_a),
    .busy(busy_a), .grant_id(grant_id_a), .timeout_err(timeout_err_a), .clr_err(clr_err)
  );

  resp_arb #(.NUM_SRC(3), .DATA_W(8), .RR_MODE(0), .TO_CYC(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .src_req(src_req_b), .src_data(src_data),
    .src_lock(3'b000), .src_ack(src_ack_b), .src_done(src_done_b),
    .resp_data(resp_data_b), .send_resp(send_resp_b), .resp_sent(resp_sent_b),
    .busy(busy_b), .grant_id(grant_id_b), .timeout_err(timeout_err_b), .clr_err(clr_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n       = 1'b0;
    src_req_a   = '0;
    src_req_b   = '0;
    src_lock_a  = '0;
    resp_sent_a = 1'b0;
    resp_sent_b = 1'b0;
    clr_err     = 1'b0;
    src_data    = 24'hC2_B1_A0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Advance until send_resp is seen on the chosen DUT, within a bounded budget.
  task automatic wait_send(input bit use_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((use_b ? send_resp_b : send_resp_a) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("[TB] FAIL send_wait: got no send_resp expected one within 20 cycles");
    end
  endtask

  // From a SEND cycle: resp_sent two cycles later, ends on the src_done cycle.
  task automatic complete(input bit use_b);
    tick();
    tick();
    if (use_b) resp_sent_b = 1'b1; else resp_sent_a = 1'b1;
    tick();
    resp_sent_a = 1'b0;
    resp_sent_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    src_req_a  = 3'b111;
    src_req_b  = 3'b111;
    src_lock_a = '0;
    resp_sent_a = 1'b0;
    resp_sent_b = 1'b0;
    clr_err    = 1'b0;
    src_data   = 24'hC2_B1_A0;
    repeat (2) tick();
    tests++;
    if ({send_resp_a, src_ack_a, src_done_a, busy_a, grant_id_a, resp_data_a, timeout_err_a} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_a: got %0h expected 0",
               {send_resp_a, src_ack_a, src_done_a, busy_a, grant_id_a, resp_data_a, timeout_err_a});
    end
    tests++;
    if ({send_resp_b, src_ack_b, src_done_b, busy_b, grant_id_b, resp_data_b, timeout_err_b} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_b: got %0h expected 0",
               {send_resp_b, src_ack_b, src_done_b, busy_b, grant_id_b, resp_data_b, timeout_err_b});
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if ({send_resp_a, src_ack_a, grant_id_a, resp_data_a} !== {1'b1, 3'b001, 2'd0, 8'hA0}) begin
      fails++;
      $display("[TB] FAIL first_grant: got %0h expected %0h",
               {send_resp_a, src_ack_a, grant_id_a, resp_data_a}, {1'b1, 3'b001, 2'd0, 8'hA0});
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [1:0] order [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [7:0] exp_data;
    reset_dut();
    src_req_a = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_send(1'b0, ok);
      exp_data = 8'hA0 + 8'h11 * order[i];
      tests++;
      if (grant_id_a !== order[i]) begin
        fails++;
        $display("[TB] FAIL rr_grant[%0d]: got %0d expected %0d", i, grant_id_a, order[i]);
      end
      tests++;
      if (resp_data_a !== exp_data || src_ack_a !== (3'b001 << order[i])) begin
        fails++;
        $display("[TB] FAIL rr_data_ack[%0d]: got %0h/%b expected %0h/%b",
                 i, resp_data_a, src_ack_a, exp_data, 3'b001 << order[i]);
      end
      complete(1'b0);
      tests++;
      if (src_done_a !== (3'b001 << order[i])) begin
        fails++;
        $display("[TB] FAIL rr_done[%0d]: got %b expected %b", i, src_done_a, 3'b001 << order[i]);
      end
    end
    src_req_a = '0;
  endtask

  task automatic test_fixed_priority();
    bit ok;
    reset_dut();
    src_req_b = 3'b110;
    for (int i = 0; i < 3; i++) begin
      wait_send(1'b1, ok);
      tests++;
      if (grant_id_b !== 2'd1 || src_ack_b !== 3'b010) begin
        fails++;
        $display("[TB] FAIL fp_grant[%0d]: got %0d/%b expected 1/010", i, grant_id_b, src_ack_b);
      end
      complete(1'b1);
    end
    src_req_b = 3'b100;
    wait_send(1'b1, ok);
    tests++;
    if (grant_id_b !== 2'd2 || resp_data_b !== 8'hC2) begin
      fails++;
      $display("[TB] FAIL fp_starved_src: got %0d/%0h expected 2/c2", grant_id_b, resp_data_b);
    end
    complete(1'b1);
    src_req_b = '0;
  endtask

  task automatic test_lock();
    bit ok;
    int sends;
    reset_dut();
    src_lock_a = 3'b010;
    src_req_a  = 3'b010;
    for (int i = 0; i < 4; i++) begin
      wait_send(1'b0, ok);
      tests++;
      if (grant_id_a !== 2'd1) begin
        fails++;
        $display("[TB] FAIL lock_burst[%0d]: got %0d expected 1", i, grant_id_a);
      end
      src_req_a = 3'b011;
      complete(1'b0);
      if (i == 2) begin
        src_req_a = 3'b001;
        sends = 0;
        repeat (5) begin
          tick();
          if (send_resp_a === 1'b1) sends++;
        end
        tests++;
        if (sends !== 0) begin
          fails++;
          $display("[TB] FAIL lock_gap: got %0d sends expected 0", sends);
        end
        src_req_a = 3'b011;
      end
    end
    src_lock_a = '0;
    src_req_a  = 3'b001;
    wait_send(1'b0, ok);
    tests++;
    if (grant_id_a !== 2'd0) begin
      fails++;
      $display("[TB] FAIL lock_release: got %0d expected 0", grant_id_a);
    end
    src_req_a = '0;
    complete(1'b0);
  endtask

  task automatic test_timeout();
    bit ok;
    reset_dut();
    src_req_a = 3'b001;
    wait_send(1'b0, ok);
    src_req_a = '0;
    repeat (10) tick();
    tests++;
    if (timeout_err_a !== 1'b0 || busy_a !== 1'b1) begin
      fails++;
      $display("[TB] FAIL to_early: got err=%b busy=%b expected err=0 busy=1", timeout_err_a, busy_a);
    end
    tick();
    tests++;
    if ({timeout_err_a, src_done_a, busy_a} !== {1'b1, 3'b001, 1'b0}) begin
      fails++;
      $display("[TB] FAIL to_expire: got %b expected %b", {timeout_err_a, src_done_a, busy_a}, 5'b1_001_0);
    end
    tick();
    tests++;
    if (timeout_err_a !== 1'b1 || src_done_a !== 3'b000) begin
      fails++;
      $display("[TB] FAIL to_sticky: got err=%b done=%b expected err=1 done=000", timeout_err_a, src_done_a);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tests++;
    if (timeout_err_a !== 1'b0) begin
      fails++;
      $display("[TB] FAIL to_clear: got %b expected 0", timeout_err_a);
    end
  endtask

  task automatic test_boundary();
    bit ok;
    reset_dut();
    src_req_a = 3'b001;
    wait_send(1'b0, ok);
    src_req_a   = '0;
    resp_sent_a = 1'b1;
    tick();
    resp_sent_a = 1'b0;
    tick();
    tests++;
    if (src_done_a !== 3'b000 || busy_a !== 1'b1) begin
      fails++;
      $display("[TB] FAIL early_sent: got done=%b busy=%b expected done=000 busy=1", src_done_a, busy_a);
    end
    resp_sent_a = 1'b1;
    tick();
    resp_sent_a = 1'b0;
    tests++;
    if (src_done_a !== 3'b001) begin
      fails++;
      $display("[TB] FAIL late_sent: got %b expected 001", src_done_a);
    end

    reset_dut();
    src_req_a = 3'b100;
    wait_send(1'b0, ok);
    src_req_a = '0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({send_resp_a, src_ack_a, src_done_a, busy_a, grant_id_a, resp_data_a, timeout_err_a} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_in_wait: got %0h expected 0",
               {send_resp_a, src_ack_a, src_done_a, busy_a, grant_id_a, resp_data_a, timeout_err_a});
    end
    resp_sent_a = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    resp_sent_a = 1'b0;
    tests++;
    if (src_done_a !== 3'b000 || busy_a !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abandoned_done: got done=%b busy=%b expected done=000 busy=0", src_done_a, busy_a);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_lock();
    test_timeout();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/resp_arb.md
# resp_arb

Parametrised response arbiter for the oscilloscope digital core. It serialises response bytes from NUM_SRC independent producers onto the single UART transmit handshake (resp_data / send_resp / resp_sent); typical producers are command config, RAM trace dump and EEPROM readback. It replaces the fixed OR-merge of producer strobes with these features:
- registered per-source request/acknowledge;
- fixed-priority or round-robin arbitration;
- burst lock, so a trace dump is never interleaved with command responses;
- a resp_sent watchdog.

## Interface
- NUM_SRC, 3, number of response producers (2..8)
- DATA_W, 8, response byte width
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)
- TO_CYC, 65535, cycles allowed from send_resp to resp_sent before timeout (≥2)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- src_req  in  NUM_SRC  per-source request; held high with data stable until src_ack
- src_data  in  NUM_SRC*DATA_W  per-source byte; source i occupies bits [i*DATA_W +: DATA_W]
- src_lock  in  NUM_SRC  granted source keeps ownership while high
- src_ack  out  NUM_SRC  1-cycle pulse: byte captured, source may change data/req
- src_done  out  NUM_SRC  1-cycle pulse: byte finished on UART (or timed out)
- resp_data  out  DATA_W  registered byte to UART
- send_resp  out  1  1-cycle transmit strobe to UART
- resp_sent  in  1  UART finished byte
- busy  out  1  high in SEND and WAIT
- grant_id  out  $clog2(NUM_SRC)  index of the current/last granted source
- timeout_err  out  1  sticky; set on watchdog expiry
- clr_err  in  1  synchronous clear of timeout_err

## Operation
- **FSM states:** IDLE, SEND, WAIT.
- **IDLE:**
  - If any eligible src_req is high: pick winner g, register resp_data ← src_data[g] and grant_id ← g, go to SEND.
  - Otherwise stay in IDLE.
- **SEND (one cycle):**
  - send_resp = 1, src_ack[g] = 1, watchdog cleared.
  - Always go to WAIT.
- **WAIT:**
  - On resp_sent: src_done[g] = 1, update the round-robin pointer to g+1 (mod NUM_SRC), go to IDLE.
  - On watchdog reaching TO_CYC without resp_sent: set timeout_err, pulse src_done[g], go to IDLE.
- **Eligibility:**
  - If src_lock[grant_id] is high on entry to IDLE, only grant_id is eligible. The grant holds even while its req is low, so a burst may contain gaps.
  - Otherwise all sources are eligible.
- **Arbitration:**
  - RR_MODE=1: first requester at or after the pointer, searching upward with wrap.
  - RR_MODE=0: lowest index.
  - The pointer is not advanced by locked re-grants.
- resp_sent outside WAIT is ignored.
- **timeout_err:**
  - clr_err clears it.
  - A set in the same cycle as clr_err wins.
- An unused index (NUM_SRC not a power of 2) is never granted.

## Timing
- **Reset values:**
  - All outputs 0: resp_data, send_resp, src_ack, src_done, busy, grant_id, timeout_err.
  - FSM in IDLE, RR pointer 0, watchdog 0.
- **Reset behaviour:**
  - Reset asserted mid-transfer takes effect immediately.
  - No src_done is issued for an abandoned byte.
- **Request-to-strobe latency:** src_req seen high in IDLE at cycle N → send_resp and src_ack at N+1.
- **Done latency:** resp_sent at cycle M in WAIT → src_done at M+1, IDLE at M+1.
- **Next grant:** evaluated at M+1, so send_resp is asserted no earlier than M+2.
- **Minimum byte period:** 3 cycles plus UART time.
- **Request retention:** a source whose req is still high after src_ack is re-requesting; no deassert cycle is required.
- **Data stability:** resp_data is stable from SEND until the next SEND.
- **Watchdog:** counts from the first WAIT cycle. Expiry occurs on the cycle the count reaches TO_CYC; that cycle sets timeout_err and pulses src_done[g].

## Structure
- **resp_arb_pkg** contains:
  - the state enum typedef (IDLE/SEND/WAIT);
  - the clog2-based width helper for the index/pointer width.
- **rr_pick** sub-module:
  - Purely combinational.
  - Inputs: request vector, pointer, mode.
  - Outputs: one-hot grant and encoded index.
- The top level holds the FSM, capture registers, pointer, watchdog and error flag.

## Test plan
- **Reset:** NUM_SRC=3; reset with all req high → every output 0. First grant after release goes to source 0; send_resp at cycle 1 after release.
- **Round-robin:** req=3'b111 held, resp_sent returned 2 cycles after each send_resp → grant order 0,1,2,0. Each resp_data matches src_data[g] (0xA0/0xB1/0xC2).
- **Fixed priority:** RR_MODE=0, req=3'b110 held → source 1 wins every time; source 2 starves while source 1 requests.
- **Lock:**
  - Source 1 asserts lock and sends 4 bytes with a 5-cycle req gap; source 0 requests throughout → 4 consecutive grants to 1, none to 0 during the burst.
  - After lock drops, source 0 is granted next.
- **Timeout:** TO_CYC=10, resp_sent never asserted → timeout_err set and src_done[g] pulsed, 10 cycles after the first WAIT cycle. FSM returns to IDLE; clr_err clears timeout_err.
- **Boundary:**
  - resp_sent coincident with send_resp → ignored; transfer completes only on the later resp_sent.
  - rst_n asserted in WAIT → outputs 0 immediately, no src_done.
